// File: rtl/serial_frame_receiver.sv
`timescale 1ns/1ps
// serial_frame_receiver: deserializes idle-high, start/stop framed MSB-first words
// into a one-entry Valid/Ready buffer with sticky framing-error and overrun flags.
module serial_frame_receiver #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Enable,
    input  logic         SerialIn,
    input  logic         Ready,
    input  logic         ClearFlags,
    output logic [N-1:0] Data,
    output logic         Valid,
    output logic         Busy,
    output logic         FrameError,
    output logic         Overrun
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0] shreg;
    logic good_stop, bad_stop, load, drop;
    assign Busy = state != IDLE;
    assign good_stop = Enable && state == STOP && SerialIn;
    assign bad_stop = Enable && state == STOP && !SerialIn;
    // a consumer taking the old word on the stop edge frees the slot for the new one
    assign load = good_stop && (!Valid || Ready);
    assign drop = good_stop && Valid && !Ready;
    always_comb begin
        state_nxt = state;
        if (Enable)
            state_nxt = state == IDLE ? (SerialIn ? IDLE : DATA) :
                        state == DATA ? (cnt == CW'(N - 1) ? STOP : DATA) : IDLE;
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else if (Enable) begin
            state <= state_nxt;
            cnt   <= state == DATA ? cnt + 1'b1 : '0;
            if (state == DATA)
                shreg <= {shreg[N-2:0], SerialIn};
        end
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Data       <= '0;
            Valid      <= 1'b0;
            FrameError <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            if (load)
                Data <= shreg;
            Valid      <= load || (Valid && !Ready);
            FrameError <= bad_stop || (FrameError && !ClearFlags);
            Overrun    <= drop || (Overrun && !ClearFlags);
        end
    end
endmodule
